accel_fifo: RTL and testbench

- Synchronous buffer FIFO that sits between the data bus router and one accelerator (FFT or FIR); one instance per direction (to_acc, from_acc).
- The write side takes put requests with a 32-bit word. The read side takes get requests.
- Drives the empty/full status the router arbitration uses to choose bus direction. Adds almost_full, occupancy and sticky error flags for the accelerator control logic.

---
 rtl/accel_fifo_pkg.sv | 30 +++
 rtl/accel_fifo_mem.sv | 44 ++++
 rtl/accel_fifo.sv | 162 ++++++++++++++++
 tb/tb_accel_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/accel_fifo_pkg.sv
// Shared definitions for the accelerator buffer FIFO: default sizing used by
// the router and every FIFO instance, plus the per-cycle operation encoding.
package accel_fifo_pkg;

    // Default word width, pointer width and almost-full threshold.
    localparam int unsigned ACC_DATA_WIDTH = 32;
    localparam int unsigned ACC_FIFO_AW    = 4;
    localparam int unsigned ACC_AFULL      = 14;

    // What the FIFO accepted in a given cycle.
    typedef enum logic [1:0] {
        FIFO_OP_IDLE = 2'b00,
        FIFO_OP_GET  = 2'b01,
        FIFO_OP_PUT  = 2'b10,
        FIFO_OP_BOTH = 2'b11
    } fifo_op_e;

    // Fold the two acceptance strobes into one operation code.
    function automatic fifo_op_e fifo_op(input logic put_ok, input logic get_ok);
        fifo_op_e op;
        case ({put_ok, get_ok})
            2'b01:   op = FIFO_OP_GET;
            2'b10:   op = FIFO_OP_PUT;
            2'b11:   op = FIFO_OP_BOTH;
            default: op = FIFO_OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/accel_fifo_mem.sv
// Simple dual-port register array for the accelerator FIFO.
// Synchronous write, registered read. The storage itself is never reset; only
// the read-data register is, so the FIFO output comes up as zero.
module accel_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Storage write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: capture the addressed word, hold it when no read is issued.
    // A read and write to the same address in one cycle returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/accel_fifo.sv
// Buffer FIFO between the data bus router and one accelerator.
// Accepts put/get requests, drives registered empty/full/almost_full status
// and occupancy, and records rejected requests in sticky error flags.
// clear is a synchronous flush that wins over any request in its cycle.
module accel_fifo
    import accel_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = ACC_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = ACC_FIFO_AW,
    parameter int unsigned AFULL_THRESH = ACC_AFULL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  put_req,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  get_req,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic                  empty_r;
    logic                  full_r;
    logic                  afull_r;
    logic                  data_valid_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  get_ok_s;
    logic                  put_ok_s;
    fifo_op_e              op_s;
    logic [ADDR_WIDTH:0]   count_nxt_s;
    logic [DATA_WIDTH-1:0] rdata_s;

    // Acceptance: no bypass, so a get on an empty FIFO is always refused;
    // a put into a full FIFO succeeds only alongside an accepted get.
    always_comb begin
        get_ok_s = 1'b0;
        put_ok_s = 1'b0;
        if (clear) begin
            get_ok_s = 1'b0;
            put_ok_s = 1'b0;
        end else begin
            get_ok_s = get_req & ~empty_r;
            put_ok_s = put_req & (~full_r | get_ok_s);
        end
    end

    assign op_s = fifo_op(put_ok_s, get_ok_s);

    // Next occupancy: +1 on put only, -1 on get only, otherwise unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case (op_s)
            FIFO_OP_PUT:  count_nxt_s = count_r + (ADDR_WIDTH+1)'(1);
            FIFO_OP_GET:  count_nxt_s = count_r - (ADDR_WIDTH+1)'(1);
            FIFO_OP_BOTH: count_nxt_s = count_r;
            FIFO_OP_IDLE: count_nxt_s = count_r;
            default:      count_nxt_s = count_r;
        endcase
    end

    // Pointer update; pointers wrap naturally at the array size.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r <= {ADDR_WIDTH{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            if (put_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
            end
            if (get_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
            end
        end
    end

    // Occupancy and status flags, all derived from the next count so they
    // always agree with count in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {(ADDR_WIDTH+1){1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            afull_r <= 1'b0;
        end else if (clear) begin
            count_r <= {(ADDR_WIDTH+1){1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            afull_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == {(ADDR_WIDTH+1){1'b0}});
            full_r  <= (count_nxt_s == DEPTH_C);
            afull_r <= (count_nxt_s >= AFULL_C);
        end
    end

    // Read-data strobe: one pulse in the cycle after an accepted get.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_valid_r <= 1'b0;
        end else if (clear) begin
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= get_ok_s;
        end
    end

    // Sticky error flags for rejected requests; only clear or reset drop them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (clear) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r  | (put_req & ~put_ok_s);
            underflow_r <= underflow_r | (get_req & ~get_ok_s);
        end
    end

    accel_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (reset),
        .we    (put_ok_s),
        .waddr (wr_ptr_r),
        .wdata (data_in),
        .re    (get_ok_s),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    assign data_out    = rdata_s;
    assign data_valid  = data_valid_r;
    assign empty       = empty_r;
    assign full        = full_r;
    assign almost_full = afull_r;
    assign count       = count_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;

endmodule

// File: tb/tb_accel_fifo.sv
// Directed plus randomized bench for accel_fifo. A queue-based reference
// model tracks the stored words, read data and sticky flags.
module tb_accel_fifo;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        put_req;
    logic [31:0] data_in;
    logic        get_req;
    logic [31:0] data_out;
    logic        data_valid;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] q[$];
    logic [31:0] m_dout;
    bit          m_dv;
    bit          m_ovf;
    bit          m_unf;

    accel_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .put_req     (put_req),
        .data_in     (data_in),
        .get_req     (get_req),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ".count"},     {27'd0, count},       n);
        check({tag, ".empty"},     {31'd0, empty},       (n == 0)  ? 32'd1 : 32'd0);
        check({tag, ".full"},      {31'd0, full},        (n == 16) ? 32'd1 : 32'd0);
        check({tag, ".afull"},     {31'd0, almost_full}, (n >= 14) ? 32'd1 : 32'd0);
        check({tag, ".overflow"},  {31'd0, overflow},    {31'd0, m_ovf});
        check({tag, ".underflow"}, {31'd0, underflow},   {31'd0, m_unf});
        check({tag, ".dvalid"},    {31'd0, data_valid},  {31'd0, m_dv});
        check({tag, ".dout"},      data_out,             m_dout);
    endtask

    // One clock cycle with the given requests, then model update and checks.
    task automatic step(input string tag, input bit p, input logic [31:0] d,
                        input bit g, input bit c);
        bit get_ok;
        bit put_ok;
        put_req = p;
        data_in = d;
        get_req = g;
        clear   = c;
        get_ok  = g && !c && (q.size() > 0);
        put_ok  = p && !c && ((q.size() < 16) || get_ok);
        @(posedge clk);
        #1;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_dv  = 1'b0;
        end else begin
            if (get_ok) begin
                m_dout = q.pop_front();
                m_dv   = 1'b1;
            end else begin
                m_dv = 1'b0;
            end
            if (put_ok) q.push_back(d);
            if (p && !put_ok) m_ovf = 1'b1;
            if (g && !get_ok) m_unf = 1'b1;
        end
        put_req = 1'b0;
        get_req = 1'b0;
        clear   = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = 32'd0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        clear   = 1'b0;
        put_req = 1'b0;
        get_req = 1'b0;
        data_in = 32'd0;
        model_reset();

        // power-on reset
        #12;
        check_all("por");
        @(negedge clk);
        reset = 1'b1;

        // asynchronous reset mid-stream after 5 puts
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, $urandom, 1'b0, 1'b0);
        check("pre_rst.n", {27'd0, count}, 32'd5);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b1;
        step("get_after_rst", 1'b0, 32'd0, 1'b1, 1'b0);
        check("rst_underflow", {31'd0, underflow}, 32'd1);
        step("clr0", 1'b0, 32'd0, 1'b0, 1'b1);

        // fill with 1..16, then one rejected put
        for (int i = 1; i <= 16; i++) begin
            step("fill", 1'b1, 32'(i), 1'b0, 1'b0);
            check("fill.afull_thr", {31'd0, almost_full}, (i >= 14) ? 32'd1 : 32'd0);
        end
        check("fill.full", {31'd0, full}, 32'd1);
        step("fill17", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        check("ovf.set", {31'd0, overflow}, 32'd1);
        check("ovf.count", {27'd0, count}, 32'd16);

        // drain in order, then one rejected get
        for (int i = 1; i <= 16; i++) begin
            step("drain", 1'b0, 32'd0, 1'b1, 1'b0);
            check("drain.order", data_out, 32'(i));
        end
        check("drain.empty", {31'd0, empty}, 32'd1);
        step("drain_extra", 1'b0, 32'd0, 1'b1, 1'b0);
        check("unf.set", {31'd0, underflow}, 32'd1);
        step("clr1", 1'b0, 32'd0, 1'b0, 1'b1);

        // wrap-around traffic
        for (int i = 0; i < 10; i++) step("wrap_p10", 1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("wrap_g10", 1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step("wrap_p12", 1'b1, $urandom, 1'b0, 1'b0);
        check("wrap.peak", {27'd0, count}, 32'd12);
        for (int i = 0; i < 12; i++) step("wrap_g12", 1'b0, 32'd0, 1'b1, 1'b0);
        check("wrap.noerr", {30'd0, overflow, underflow}, 32'd0);

        // simultaneous put+get on full
        for (int i = 0; i < 16; i++) step("sim_fill", 1'b1, $urandom, 1'b0, 1'b0);
        step("sim_full", 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
        check("sim_full.count", {27'd0, count}, 32'd16);
        check("sim_full.ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 16; i++) step("sim_drain", 1'b0, 32'd0, 1'b1, 1'b0);
        check("sim_full.a5", data_out, 32'hA5A5A5A5);

        // simultaneous put+get on empty
        step("sim_empty", 1'b1, 32'h12345678, 1'b1, 1'b0);
        check("sim_empty.count", {27'd0, count}, 32'd1);
        check("sim_empty.unf", {31'd0, underflow}, 32'd1);
        step("sim_empty_get", 1'b0, 32'd0, 1'b1, 1'b0);

        // clear during traffic
        for (int i = 0; i < 7; i++) step("clr_fill", 1'b1, $urandom, 1'b0, 1'b0);
        step("clr_traffic", 1'b1, 32'hCAFEF00D, 1'b1, 1'b1);
        check("clr.count", {27'd0, count}, 32'd0);
        check("clr.flags", {28'd0, empty, data_valid, overflow, underflow}, 32'h8);
        step("clr_put", 1'b1, 32'h0BADC0DE, 1'b0, 1'b0);
        step("clr_get", 1'b0, 32'd0, 1'b1, 1'b0);
        check("clr.newword", data_out, 32'h0BADC0DE);

        // randomized traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 99) < 55),
                 $urandom,
                 ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
